// File: rtl/lfsr_pkg.sv
// Shared types, maximal-length tap masks and helpers for the LFSR generator.
// Tap mask bit i set means state[i] feeds the XOR feedback.
package lfsr_pkg;

    localparam logic [3:0]  TAPS4  = 4'hC;
    localparam logic [4:0]  TAPS5  = 5'h14;
    localparam logic [5:0]  TAPS6  = 6'h30;
    localparam logic [6:0]  TAPS7  = 7'h60;
    localparam logic [7:0]  TAPS8  = 8'hB8;
    localparam logic [8:0]  TAPS9  = 9'h110;
    localparam logic [9:0]  TAPS10 = 10'h240;
    localparam logic [10:0] TAPS11 = 11'h500;
    localparam logic [11:0] TAPS12 = 12'h829;
    localparam logic [12:0] TAPS13 = 13'h100D;
    localparam logic [13:0] TAPS14 = 14'h2015;
    localparam logic [14:0] TAPS15 = 15'h6000;
    localparam logic [15:0] TAPS16 = 16'hD008;
    localparam logic [16:0] TAPS17 = 17'h12000;
    localparam logic [17:0] TAPS18 = 18'h20400;
    localparam logic [18:0] TAPS19 = 19'h40023;
    localparam logic [19:0] TAPS20 = 20'h90000;
    localparam logic [20:0] TAPS21 = 21'h140000;
    localparam logic [21:0] TAPS22 = 22'h300000;
    localparam logic [22:0] TAPS23 = 23'h420000;
    localparam logic [23:0] TAPS24 = 24'hE10000;
    localparam logic [24:0] TAPS25 = 25'h1200000;
    localparam logic [25:0] TAPS26 = 26'h2000023;
    localparam logic [26:0] TAPS27 = 27'h4000013;
    localparam logic [27:0] TAPS28 = 28'h9000000;
    localparam logic [28:0] TAPS29 = 29'h14000000;
    localparam logic [29:0] TAPS30 = 30'h20000029;
    localparam logic [30:0] TAPS31 = 31'h48000000;
    localparam logic [31:0] TAPS32 = 32'hA3000000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } rng_state_e;

    // Index of the highest set bit plus one; zero for a zero input.
    function automatic int bitlen(input logic [31:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) n = i + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR state register with seed load and lock-up recovery.
// A load always wins over a shift on the same edge.
module lfsr_core #(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(16'hD008),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             shift_i,
    output logic [WIDTH-1:0] state_o
);

    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
    localparam logic [WIDTH-1:0] SEED_C = (SEED == '0) ? ONE : SEED;

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] ld;

    always_comb begin
        nxt = {q[WIDTH-2:0], ^(q & TAPS)};
        if (q == '0) nxt = ONE;
        ld = (load_val_i == '0) ? ONE : load_val_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q <= SEED_C;
        end else if (load_i) begin
            q <= ld;
        end else if (shift_i) begin
            q <= nxt;
        end
    end

    assign state_o = q;

endmodule

// File: rtl/lfsr_rng.sv
// LFSR random source with free-run stepping and a bounded draw port
// using masked rejection sampling and a subtract fallback.
module lfsr_rng
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH          = 16,
    parameter logic [WIDTH-1:0] TAPS           = WIDTH'(TAPS16),
    parameter logic [WIDTH-1:0] SEED           = WIDTH'(1),
    parameter int unsigned      OUT_W          = 8,
    parameter int unsigned      STEPS_PER_DRAW = 1,
    parameter int unsigned      MAX_TRIES      = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             step_i,
    input  logic             seed_valid_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [WIDTH-1:0] rand_o,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [OUT_W-1:0] bound_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [OUT_W-1:0] rsp_data_o,
    output logic             rsp_fallback_o,
    output logic [3:0]       rsp_tries_o
);

    localparam logic [3:0] LAST_STEP = 4'(STEPS_PER_DRAW - 1);
    localparam logic [3:0] TRY_MAX   = 4'(MAX_TRIES);

    rng_state_e       st_q;
    logic [3:0]       tries_q;
    logic [3:0]       cnt_q;
    logic [OUT_W-1:0] bound_q;
    logic [OUT_W-1:0] data_q;
    logic [3:0]       rtries_q;
    logic             fb_q;

    logic [WIDTH-1:0] state;
    logic             do_shift;
    logic             accept_req;

    logic [OUT_W-1:0] low;
    logic [OUT_W-1:0] bm1;
    logic [OUT_W-1:0] mask;
    logic [OUT_W-1:0] cand;
    logic [OUT_W-1:0] res;
    logic             is_full;
    logic             in_rng;
    logic             retry;
    logic             take;
    int               k;

    assign accept_req = (st_q == ST_IDLE) && req_valid_i;
    assign do_shift   = (st_q == ST_SHIFT)
                      || ((st_q == ST_IDLE) && step_i && !req_valid_i);

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (seed_valid_i),
        .load_val_i (seed_i),
        .shift_i    (do_shift),
        .state_o    (state)
    );

    // Mask to the smallest power of two covering bound-1 before rejecting.
    always_comb begin
        low  = state[OUT_W-1:0];
        bm1  = bound_q - OUT_W'(1);
        k    = bitlen(32'(bm1));
        mask = '0;
        for (int i = 0; i < int'(OUT_W); i++) begin
            mask[i] = (i < k);
        end
        cand    = low & mask;
        is_full = (bound_q == '0);
        in_rng  = !is_full && (cand < bound_q);
        retry   = 1'b0;
        take    = 1'b0;
        res     = cand - bound_q;
        unique case (1'b1)
            is_full: begin
                take = 1'b1;
                res  = low;
            end
            in_rng: begin
                take = 1'b1;
                res  = cand;
            end
            default: begin
                retry = (tries_q < TRY_MAX);
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q     <= ST_IDLE;
            tries_q  <= '0;
            cnt_q    <= '0;
            bound_q  <= '0;
            data_q   <= '0;
            rtries_q <= '0;
            fb_q     <= 1'b0;
        end else begin
            unique case (st_q)
                ST_IDLE: begin
                    if (accept_req) begin
                        bound_q <= bound_i;
                        tries_q <= 4'd1;
                        cnt_q   <= '0;
                        st_q    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_q == LAST_STEP) begin
                        cnt_q <= '0;
                        st_q  <= ST_CHECK;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ST_CHECK: begin
                    if (retry) begin
                        tries_q <= tries_q + 4'd1;
                        st_q    <= ST_SHIFT;
                    end else begin
                        data_q   <= res;
                        rtries_q <= tries_q;
                        fb_q     <= !take;
                        st_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready_i) st_q <= ST_IDLE;
                end
                default: st_q <= ST_IDLE;
            endcase
        end
    end

    assign rand_o         = state;
    assign req_ready_o    = (st_q == ST_IDLE);
    assign rsp_valid_o    = (st_q == ST_DONE);
    assign rsp_data_o     = data_q;
    assign rsp_fallback_o = fb_q;
    assign rsp_tries_o    = rtries_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// Self-checking bench for lfsr_rng: vector table plus hand sequences,
// responses checked through an expected-result queue.
module tb_lfsr_rng;

    typedef struct {
        logic [7:0] d;
        logic [3:0] t;
        logic       fb;
    } exp_t;

    typedef struct {
        logic [15:0] seed;
        logic [7:0]  bound;
        logic        step_acc;
        exp_t        e;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, step, seed_valid, req_valid, rsp_ready;
    logic [15:0] seed;
    logic [7:0]  bound;
    logic [15:0] rand_o;
    logic        req_ready, rsp_valid, rsp_fb;
    logic [7:0]  rsp_data;
    logic [3:0]  rsp_tries;

    logic        b_step, b_seed_valid, b_req_valid, b_rsp_ready;
    logic [15:0] b_seed;
    logic [7:0]  b_bound;
    logic [15:0] b_rand;
    logic        b_req_ready, b_rsp_valid, b_rsp_fb;
    logic [7:0]  b_rsp_data;
    logic [3:0]  b_rsp_tries;

    lfsr_rng dut (
        .clk_i(clk), .rst_i(rst), .step_i(step),
        .seed_valid_i(seed_valid), .seed_i(seed), .rand_o(rand_o),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .bound_i(bound), .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .rsp_fallback_o(rsp_fb), .rsp_tries_o(rsp_tries)
    );

    lfsr_rng #(.MAX_TRIES(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .step_i(b_step),
        .seed_valid_i(b_seed_valid), .seed_i(b_seed), .rand_o(b_rand),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready),
        .bound_i(b_bound), .rsp_valid_o(b_rsp_valid),
        .rsp_ready_i(b_rsp_ready), .rsp_data_o(b_rsp_data),
        .rsp_fallback_o(b_rsp_fb), .rsp_tries_o(b_rsp_tries)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] nx(input logic [15:0] s);
        if (s == 16'h0) return 16'h1;
        return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
    endfunction

    function automatic exp_t model(input logic [15:0] sd,
                                   input logic [7:0] bnd, input int maxt);
        exp_t        e;
        logic [15:0] s;
        int          m;
        int          c;
        s = (sd == 16'h0) ? 16'h1 : sd;
        m = 0;
        while (m < int'(bnd) - 1) m = m * 2 + 1;
        e.d = '0; e.t = '0; e.fb = 1'b0;
        for (int t = 1; t <= maxt; t++) begin
            s = nx(s);
            c = int'(s[7:0]) & m;
            e.t = 4'(t);
            if (bnd == 8'h0) begin
                e.d = s[7:0];
                return e;
            end
            if (c < int'(bnd)) begin
                e.d = 8'(c);
                return e;
            end
            if (t == maxt) begin
                e.d = 8'(c - int'(bnd));
                e.fb = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic run_draw(input string nm, input logic [15:0] sd,
                            input logic [7:0] bnd, input logic st_acc,
                            input exp_t e);
        exp_t got;
        int   n;
        seed_valid = 1'b1; seed = sd;
        tick();
        seed_valid = 1'b0;
        chk({nm, "_seed"}, 32'(rand_o), (sd == 16'h0) ? 32'h1 : 32'(sd));
        req_valid = 1'b1; bound = bnd; step = st_acc;
        chk({nm, "_req_ready"}, 32'(req_ready), 32'h1);
        tick();
        req_valid = 1'b0; step = 1'b0;
        sb.push_back(e);
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        got = sb.pop_front();
        if (!rsp_valid) begin
            n_checks++; n_fail++;
            $display("FAIL %s_timeout: no rsp_valid after %0d cycles", nm, n);
        end else begin
            chk({nm, "_data"}, 32'(rsp_data), 32'(got.d));
            chk({nm, "_tries"}, 32'(rsp_tries), 32'(got.t));
            chk({nm, "_fb"}, 32'(rsp_fb), 32'(got.fb));
            chk({nm, "_latency"}, 32'(n), 32'(2 * int'(got.t)));
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            chk({nm, "_valid_drop"}, 32'(rsp_valid), 32'h0);
            chk({nm, "_ready_back"}, 32'(req_ready), 32'h1);
        end
    endtask

    initial begin
        logic [7:0] bl[4];
        exp_t       e;
        int         n;
        bl[0] = 8'd7; bl[1] = 8'd100; bl[2] = 8'd200; bl[3] = 8'd255;

        vecs[0] = '{16'h0001, 8'd0, 1'b0, '{8'h02, 4'd1, 1'b0}};
        vecs[1] = '{16'h0009, 8'd3, 1'b0, '{8'h02, 4'd2, 1'b0}};
        vecs[2] = '{16'hACE1, 8'd1, 1'b0, '{8'h00, 4'd1, 1'b0}};
        vecs[3] = '{16'hACE1, 8'd0, 1'b0, '{8'hC3, 4'd1, 1'b0}};
        vecs[4] = '{16'h0001, 8'd0, 1'b1, '{8'h02, 4'd1, 1'b0}};
        for (int i = 5; i < 8; i++) begin
            vecs[i].seed     = 16'($urandom);
            vecs[i].bound    = bl[$urandom_range(0, 3)];
            vecs[i].step_acc = 1'b0;
            vecs[i].e        = model(vecs[i].seed, vecs[i].bound, 4);
        end

        rst = 1'b1; step = 1'b0; seed_valid = 1'b0; seed = '0;
        req_valid = 1'b0; bound = '0; rsp_ready = 1'b0;
        b_step = 1'b0; b_seed_valid = 1'b0; b_seed = '0;
        b_req_valid = 1'b0; b_bound = '0; b_rsp_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;

        chk("rst_rand", 32'(rand_o), 32'h1);
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_data", 32'(rsp_data), 32'h0);
        chk("rst_tries", 32'(rsp_tries), 32'h0);
        chk("rst_fb", 32'(rsp_fb), 32'h0);

        step = 1'b1; tick(); chk("step1", 32'(rand_o), 32'h0002);
        tick(); chk("step2", 32'(rand_o), 32'h0004);
        tick(); chk("step3", 32'(rand_o), 32'h0008);
        tick(); chk("step4", 32'(rand_o), 32'h0011);
        step = 1'b0;

        seed_valid = 1'b1; seed = 16'h0000; tick();
        chk("seed_zero", 32'(rand_o), 32'h0001);
        seed = 16'hACE1; tick();
        seed_valid = 1'b0;
        chk("seed_ace1", 32'(rand_o), 32'hACE1);

        for (int i = 0; i < 8; i++) begin
            run_draw($sformatf("vec%0d", i), vecs[i].seed, vecs[i].bound,
                     vecs[i].step_acc, vecs[i].e);
        end

        // Seed load during SHIFT replaces that edge's shift.
        seed_valid = 1'b1; seed = 16'h0001; tick();
        req_valid = 1'b1; bound = 8'd0; seed_valid = 1'b0; tick();
        req_valid = 1'b0;
        seed_valid = 1'b1; seed = 16'h0009; tick();
        seed_valid = 1'b0;
        chk("midseed_rand", 32'(rand_o), 32'h0009);
        tick();
        chk("midseed_valid", 32'(rsp_valid), 32'h1);
        chk("midseed_data", 32'(rsp_data), 32'h09);
        chk("midseed_tries", 32'(rsp_tries), 32'h1);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

        b_seed_valid = 1'b1; b_seed = 16'h0009; tick();
        b_seed_valid = 1'b0;
        b_req_valid = 1'b1; b_bound = 8'd3; tick();
        b_req_valid = 1'b0;
        n = 0;
        while (!b_rsp_valid && n < 40) begin tick(); n++; end
        if (!b_rsp_valid) begin
            n_checks++; n_fail++;
            $display("FAIL fallback_timeout: no rsp_valid after %0d", n);
        end else begin
            chk("fallback_data", 32'(b_rsp_data), 32'h0);
            chk("fallback_fb", 32'(b_rsp_fb), 32'h1);
            chk("fallback_tries", 32'(b_rsp_tries), 32'h1);
            chk("fallback_latency", 32'(n), 32'd2);
        end
        b_rsp_ready = 1'b1; tick(); b_rsp_ready = 1'b0;

        seed_valid = 1'b1; seed = 16'h0009; tick();
        seed_valid = 1'b0;
        req_valid = 1'b1; bound = 8'd3; tick();
        req_valid = 1'b0;
        sb.push_back('{8'h02, 4'd2, 1'b0});
        n = 0;
        while (!rsp_valid && n < 40) begin tick(); n++; end
        e = sb.pop_front();
        if (!rsp_valid) begin
            n_checks++; n_fail++;
            $display("FAIL hold_timeout: no rsp_valid after %0d", n);
        end
        step = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("hold%0d_valid", c), 32'(rsp_valid), 32'h1);
            chk($sformatf("hold%0d_data", c), 32'(rsp_data), 32'(e.d));
            chk($sformatf("hold%0d_ready", c), 32'(req_ready), 32'h0);
            chk($sformatf("hold%0d_rand", c), 32'(rand_o), 32'h0026);
        end
        step = 1'b0;
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

        seed_valid = 1'b1; seed = 16'h1234; tick();
        seed_valid = 1'b0;
        req_valid = 1'b1; bound = 8'd50; tick();
        req_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_valid", 32'(rsp_valid), 32'h0);
        chk("midrst_rand", 32'(rand_o), 32'h1);
        chk("midrst_ready", 32'(req_ready), 32'h1);
        chk("midrst_data", 32'(rsp_data), 32'h0);
        chk("midrst_tries", 32'(rsp_tries), 32'h0);
        tick(); tick();
        chk("midrst_stay_idle", 32'(rsp_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
